// File: rtl/uart_msg_sender.sv
// uart_msg_sender: UART transmitter that sends a fixed parameter message with internal baud timing
// Ports: clk, rst_n (async active-low reset, sync release)
//   start     async request, synchronised; a rising edge starts the message when idle
//   repeat_en level, sampled at message end; 1 restarts the message after REPEAT_GAP bit-times
//   abort     sync level; returns to idle at the next edge without a done pulse
//   tx        serial line, idle high
//   busy      high while a message (or repeat gap) is in progress
//   done      one-cycle pulse when a message completes normally
//   char_idx  index of the message byte being sent
module uart_msg_sender #(
    parameter int CLKS_PER_BIT = 234,
    parameter int MSG_LEN = 15,
    parameter logic [MSG_LEN*8-1:0] MSG = 120'h48656c6c6f2c20576f726c64210a00,
    parameter int DATA_BITS = 8,
    parameter int PARITY = 0,
    parameter int STOP_BITS = 1,
    parameter int NUL_TERM = 1,
    parameter int REPEAT_GAP = 0,
    localparam int IW = MSG_LEN > 1 ? $clog2(MSG_LEN) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          repeat_en,
    input  logic          abort,
    output logic          tx,
    output logic          busy,
    output logic          done,
    output logic [IW-1:0] char_idx
);
    localparam int GAP_CYC = REPEAT_GAP * CLKS_PER_BIT;
    localparam int CW = $clog2((GAP_CYC > CLKS_PER_BIT ? GAP_CYC : CLKS_PER_BIT) + 1);
    localparam logic [7:0] DMASK = 8'((16'd1 << DATA_BITS) - 16'd1);
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_END, S_GAP} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0] bcnt, bcnt_n;
    logic [7:0] sh, sh_n, ld_byte;
    logic par, par_n, tx_n, ld, bit_end;
    logic [IW-1:0] idx_n, ld_idx;
    logic [MSG_LEN*8-1:0] msg_sh;
    logic s1, s2, s3, edge_r;
    assign bit_end = cnt == CW'(CLKS_PER_BIT - 1);
    assign busy = state != S_IDLE;
    assign done = state == S_END;
    // ld marks the LOAD step: fetch byte ld_idx and either open a frame or end on a NUL.
    // It is folded into the cycle that closes the previous stop bit, so frames run back-to-back.
    always_comb begin
        state_n = state;
        cnt_n = cnt + CW'(1);
        bcnt_n = bcnt;
        sh_n = sh;
        par_n = par;
        idx_n = char_idx;
        ld = 1'b0;
        ld_idx = '0;
        case (state)
            S_IDLE: begin
                cnt_n = '0;
                ld = edge_r;
            end
            S_START: if (bit_end) begin
                state_n = S_DATA;
                cnt_n = '0;
                bcnt_n = '0;
            end
            S_DATA: if (bit_end) begin
                cnt_n = '0;
                sh_n = sh >> 1;
                bcnt_n = bcnt + 3'd1;
                if (bcnt == 3'(DATA_BITS - 1)) begin
                    state_n = PARITY != 0 ? S_PAR : S_STOP;
                    bcnt_n = '0;
                end
            end
            S_PAR: if (bit_end) begin
                state_n = S_STOP;
                cnt_n = '0;
                bcnt_n = '0;
            end
            S_STOP: if (bit_end) begin
                cnt_n = '0;
                bcnt_n = bcnt + 3'd1;
                if (bcnt == 3'(STOP_BITS - 1)) begin
                    bcnt_n = '0;
                    if (char_idx == IW'(MSG_LEN - 1)) begin
                        state_n = S_END;
                        idx_n = '0;
                    end else begin
                        ld = 1'b1;
                        ld_idx = char_idx + IW'(1);
                    end
                end
            end
            // END is the first idle cycle of the repeat gap, so GAP itself runs GAP_CYC-1 cycles
            S_END: begin
                cnt_n = '0;
                idx_n = '0;
                state_n = repeat_en ? S_GAP : S_IDLE;
                ld = repeat_en && GAP_CYC == 0;
            end
            S_GAP: ld = cnt == CW'(GAP_CYC - 2);
            default: state_n = S_IDLE;
        endcase
        msg_sh = MSG << (8 * int'(ld_idx));
        ld_byte = msg_sh[MSG_LEN*8-1 -: 8];
        if (ld) begin
            idx_n = ld_idx;
            cnt_n = '0;
            bcnt_n = '0;
            state_n = (NUL_TERM != 0 && ld_byte == 8'h00) ? S_END : S_START;
            sh_n = ld_byte & DMASK;
            par_n = ^(ld_byte & DMASK) ^ (PARITY == 1);
        end
        if (abort) begin
            state_n = S_IDLE;
            idx_n = '0;
            cnt_n = '0;
            bcnt_n = '0;
        end
        tx_n = state_n == S_START ? 1'b0 : state_n == S_DATA ? sh_n[0] : state_n == S_PAR ? par_n : 1'b1;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt <= '0;
            bcnt <= '0;
            sh <= '0;
            par <= 1'b0;
            char_idx <= '0;
            tx <= 1'b1;
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
            edge_r <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            bcnt <= bcnt_n;
            sh <= sh_n;
            par <= par_n;
            char_idx <= idx_n;
            tx <= tx_n;
            s1 <= start;
            s2 <= s1;
            s3 <= s2;
            edge_r <= s2 & ~s3;
        end
    end
endmodule
